// File: rtl/fifo_frame_drain_pkg.sv
// Shared types for the syncfifo frame drain: default word width and drain FSM states.
package fifo_frame_drain_pkg;

  localparam int DT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA
`ifdef FRAME_CSUM_EN
    , CSUM
`endif
  } drn_state_t;

endpackage

// File: rtl/fifo_frame_drain_if.sv
// syncfifo read side plus outgoing framed stream; master = drain, slave = fifo/sink side.
interface fifo_frame_drain_if
  import fifo_frame_drain_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
);

  logic                rd_en;
  logic                f_empty;
  logic [DT_WIDTH-1:0] rd_dt;
  logic [DT_WIDTH-1:0] out_dt;
  logic                out_vld;
  logic                out_rdy;
  logic                out_sof;
  logic                out_eof;

  modport master (
    output rd_en, out_dt, out_vld, out_sof, out_eof,
    input  f_empty, rd_dt, out_rdy
  );

  modport slave (
    input  rd_en, out_dt, out_vld, out_sof, out_eof,
    output f_empty, rd_dt, out_rdy
  );

endinterface

// File: rtl/drn_out_stage.sv
// Single-entry valid/ready output register carrying data plus frame markers.
module drn_out_stage
  import fifo_frame_drain_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld,
  input  logic [DT_WIDTH-1:0] ld_dt,
  input  logic                ld_sof,
  input  logic                ld_eof,
  input  logic                rdy,
  output logic                vld,
  output logic [DT_WIDTH-1:0] dt,
  output logic                sof,
  output logic                eof,
  output logic                slot_free
);

  assign slot_free = !vld || rdy;

  // A load while the held beat transfers overwrites in place, so no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dt  <= '0;
      sof <= 1'b0;
      eof <= 1'b0;
    end else if (ld) begin
      vld <= 1'b1;
      dt  <= ld_dt;
      sof <= ld_sof;
      eof <= ld_eof;
    end else if (rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_frame_drain.sv
// Pops syncfifo words into fixed FRAME_LEN frames on a registered valid/ready stream.
// FRAME_CSUM_EN appends an XOR checksum word carrying EOF to each frame.
module fifo_frame_drain
  import fifo_frame_drain_pkg::*;
#(
  parameter int DT_WIDTH   = DT_WIDTH_DEF,
  parameter int FRAME_LEN  = 4,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drn_en,
  fifo_frame_drain_if.master    bus,
  output logic [FCNT_WIDTH-1:0] frm_cnt
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  drn_state_t          state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                last;
  logic                slot_free;
  logic                pop;
  logic                ld;
  logic [DT_WIDTH-1:0] ld_dt;
  logic                ld_sof;
  logic                ld_eof;
`ifdef FRAME_CSUM_EN
  logic [DT_WIDTH-1:0] csum;
`endif

  assign last      = (cnt == LAST);
  assign bus.rd_en = pop;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ld        = 1'b0;
    ld_dt     = bus.rd_dt;
    ld_sof    = 1'b0;
    ld_eof    = 1'b0;
    case (state)
      IDLE: begin
        if (drn_en) state_nxt = DATA;
      end
      DATA: begin
        pop = !bus.f_empty && slot_free;
        if (pop) begin
          ld     = 1'b1;
          ld_sof = (cnt == '0);
`ifdef FRAME_CSUM_EN
          if (last) state_nxt = CSUM;
`else
          ld_eof = last;
          // drn_en only matters at frame boundaries
          if (last) state_nxt = drn_en ? DATA : IDLE;
`endif
        end
      end
`ifdef FRAME_CSUM_EN
      CSUM: begin
        if (slot_free) begin
          ld        = 1'b1;
          ld_dt     = csum;
          ld_eof    = 1'b1;
          state_nxt = drn_en ? DATA : IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      frm_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop) cnt <= last ? '0 : cnt + 1'b1;
      if (bus.out_vld && bus.out_rdy && bus.out_eof) frm_cnt <= frm_cnt + 1'b1;
    end
  end

`ifdef FRAME_CSUM_EN
  // Restart the running XOR on the first word of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (pop) begin
      csum <= (cnt == '0) ? bus.rd_dt : (csum ^ bus.rd_dt);
    end
  end
`endif

  drn_out_stage #(.DT_WIDTH(DT_WIDTH)) u_out (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .ld_dt     (ld_dt),
    .ld_sof    (ld_sof),
    .ld_eof    (ld_eof),
    .rdy       (bus.out_rdy),
    .vld       (bus.out_vld),
    .dt        (bus.out_dt),
    .sof       (bus.out_sof),
    .eof       (bus.out_eof),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_fifo_frame_drain.sv
// Bench for fifo_frame_drain: queue-based syncfifo model, expected-beat scoreboard, vectors and random traffic.
module tb_fifo_frame_drain;
  import fifo_frame_drain_pkg::*;

  localparam int DW = 8;
  localparam int FL = 4;
  localparam int FW = 2;
`ifdef FRAME_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] dt;
    logic          sof;
    logic          eof;
  } beat_t;

  typedef struct {
    logic          drn;
    logic          rdy;
    logic          rden;
    logic          vld;
    logic [DW-1:0] dt;
    logic          sof;
    logic          eof;
    int            frm;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          drn_en;
  logic [FW-1:0] frm_cnt;

  fifo_frame_drain_if #(.DT_WIDTH(DW)) bus ();

  fifo_frame_drain #(.DT_WIDTH(DW), .FRAME_LEN(FL), .FCNT_WIDTH(FW)) dut (
    .clk     (clk),
    .rst     (rst),
    .drn_en  (drn_en),
    .bus     (bus),
    .frm_cnt (frm_cnt)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] fq[$];
  beat_t         exp_q[$];
  int            k = 0;
  logic [DW-1:0] acc = '0;
  int            mframes = 0;
  logic          hold = 1'b0;
  beat_t         hb;
  vec_t          tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pins();
    bus.f_empty = (fq.size() == 0);
    bus.rd_dt   = (fq.size() > 0) ? fq[0] : '0;
  endtask

  // Expected stream straight from the framing rules: FL words per frame, optional XOR tail.
  task automatic push(input logic [DW-1:0] w);
    beat_t b;
    fq.push_back(w);
    acc   = (k == 0) ? w : (acc ^ w);
    b.dt  = w;
    b.sof = (k == 0);
    b.eof = (k == FL - 1) && !CS;
    exp_q.push_back(b);
    if (k == FL - 1) begin
      if (CS) begin
        b.dt  = acc;
        b.sof = 1'b0;
        b.eof = 1'b1;
        exp_q.push_back(b);
      end
      k = 0;
    end else begin
      k++;
    end
    pins();
  endtask

  task automatic flush_model();
    fq.delete();
    exp_q.delete();
    k       = 0;
    acc     = '0;
    mframes = 0;
    pins();
  endtask

  // Called at the falling edge with inputs applied; advances one full clock.
  task automatic step();
    logic  p;
    logic  x;
    beat_t cur;
    beat_t e;
    #1;
    p   = bus.rd_en;
    x   = bus.out_vld && bus.out_rdy && !rst;
    cur = {bus.out_dt, bus.out_sof, bus.out_eof};
    if (p) chk("rd_en_on_empty", 32'(bus.f_empty), 32'(0));
    if (hold) chk("hold_stable", 32'(cur), 32'(hb));
    hold = bus.out_vld && !bus.out_rdy && !rst;
    hb   = cur;
    if (x) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got %0h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 32'(cur), 32'(e));
        if (e.eof) mframes++;
      end
    end
    @(posedge clk);
    #1;
    if (p && fq.size() > 0) void'(fq.pop_front());
    pins();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    flush_model();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while ((exp_q.size() > 0 || bus.out_vld) && n < lim) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    rst         = 1'b1;
    drn_en      = 1'b0;
    bus.out_rdy = 1'b0;
    pins();
    @(negedge clk);

    // reset state
    do_reset(2);
    chk("rst_vld", 32'(bus.out_vld), 32'(0));
    chk("rst_rd_en", 32'(bus.rd_en), 32'(0));
    chk("rst_frm", 32'(frm_cnt), 32'(0));
    chk("rst_dt", 32'(bus.out_dt), 32'(0));
    chk("rst_sof", 32'(bus.out_sof), 32'(0));
    chk("rst_eof", 32'(bus.out_eof), 32'(0));

    // streaming frame, cycle by cycle
    tv.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0});
    tv.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0});
    tv.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0});
    tv.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 0});
    tv.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 0});
`ifdef FRAME_CSUM_EN
    tv.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 0});
    tv.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 0});
`else
    tv.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 0});
`endif
    tv.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1});
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    foreach (tv[i]) begin
      drn_en      = tv[i].drn;
      bus.out_rdy = tv[i].rdy;
      #1;
      chk($sformatf("tv%0d_rd_en", i), 32'(bus.rd_en), 32'(tv[i].rden));
      chk($sformatf("tv%0d_vld", i), 32'(bus.out_vld), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("tv%0d_dt", i), 32'(bus.out_dt), 32'(tv[i].dt));
        chk($sformatf("tv%0d_sof", i), 32'(bus.out_sof), 32'(tv[i].sof));
        chk($sformatf("tv%0d_eof", i), 32'(bus.out_eof), 32'(tv[i].eof));
      end
      chk($sformatf("tv%0d_frm", i), 32'(frm_cnt), 32'(tv[i].frm));
      step();
    end

    // backpressure on the second beat
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    drn_en      = 1'b1;
    bus.out_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (bus.out_vld && bus.out_dt == 8'h22) break;
      step();
    end
    chk("bp_reach_22", 32'(bus.out_vld && bus.out_dt == 8'h22), 32'(1));
    bus.out_rdy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("bp_dt", 32'(bus.out_dt), 32'(8'h22));
      chk("bp_vld", 32'(bus.out_vld), 32'(1));
      chk("bp_rd_en", 32'(bus.rd_en), 32'(0));
      step();
    end
    bus.out_rdy = 1'b1;
    drain("bp", 40);
    chk("bp_frm", 32'(frm_cnt), 32'(2));

    // fifo runs dry mid-frame
    push(8'h55); push(8'h66);
    repeat (8) step();
    #1;
    chk("uf_no_beat", 32'(bus.out_vld), 32'(0));
    chk("uf_rd_en", 32'(bus.rd_en), 32'(0));
    chk("uf_frm_hold", 32'(frm_cnt), 32'(2));
    push(8'h77); push(8'h88);
    drain("uf", 40);
    chk("uf_frm", 32'(frm_cnt), 32'(3));

    // counter wrap after five frames from reset
    do_reset(2);
    for (int i = 0; i < 5 * FL; i++) push(8'(i * 7 + 3));
    drain("wrap", 200);
    chk("wrap_frm", 32'(frm_cnt), 32'(1));

    // randomized traffic against the expected-beat queue
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 16) push(8'($urandom));
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      drn_en      = ($urandom_range(0, 7) != 0);
      step();
    end
    while (k != 0) push(8'($urandom));
    drn_en      = 1'b1;
    bus.out_rdy = 1'b1;
    drain("rand", 400);
    chk("rand_frm", 32'(frm_cnt), 32'(mframes % (1 << FW)));

    // reset in the middle of a frame
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    for (int n = 0; n < 20; n++) begin
      if (bus.out_vld) break;
      step();
    end
    chk("mid_vld_seen", 32'(bus.out_vld), 32'(1));
    bus.out_rdy = 1'b0;
    do_reset(1);
    #1;
    chk("mid_rst_vld", 32'(bus.out_vld), 32'(0));
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_frm", 32'(frm_cnt), 32'(0));
    drn_en = 1'b0;
    step();
    #1;
    chk("post_rst_vld", 32'(bus.out_vld), 32'(0));
    chk("post_rst_rd_en", 32'(bus.rd_en), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
